spi_byte_rx: RTL and testbench
==============================

# spi_byte_rx

SPI-style serial byte receiver that consumes the already-synchronized SCK, MOSI and chip-select lines produced by the two-flop `sync_low`/`sync_high` synchronizers. It detects SCK rising edges in the system clock domain, shifts in MOSI MSB-first and assembles NUM_BITS-wide words. Each word is presented in a holding register with a full/ack handshake and overrun detection. It feeds the SD-card command/data path ahead of the AES engine.

## Interface
Parameters:
- NUM_BITS, 8, word width; legal 2..32
- MSB_FIRST, 1, 1 = first received bit lands in bit NUM_BITS-1; 0 = first bit lands in bit 0

Ports:
- clk  in  1  system clock; all logic on rising edge
- n_rst  in  1  reset, synchronous and active-low
- sync_sclk  in  1  SCK after 2-FF synchronizer
- sync_mosi  in  1  MOSI after 2-FF synchronizer
- sync_ss_n  in  1  chip select after 2-FF synchronizer; active-low
- rx_ack  in  1  consumer has taken rx_data; single-cycle pulse or level
- rx_data  out  NUM_BITS  last completed word
- rx_full  out  1  rx_data holds an unconsumed word
- rx_strobe  out  1  one-cycle pulse when a word is loaded into rx_data
- rx_busy  out  1  a partial word is in progress
- overrun  out  1  sticky: a completed word was dropped because rx_full was set

## Operation
- Internal state: sclk_prev (1 b), shift_reg (NUM_BITS), bit_cnt (0..NUM_BITS-1).
- Edge detect: a cycle is a sample cycle when sync_sclk=1, sclk_prev=0 and sync_ss_n=0. sclk_prev <= sync_sclk every cycle.
- On each sample cycle, sync_mosi is shifted in:
  - MSB_FIRST=1: shift left, insert at bit 0.
  - MSB_FIRST=0: shift right, insert at bit NUM_BITS-1.
  - bit_cnt increments.
- Word completion: a sample cycle with bit_cnt = NUM_BITS-1.
  - The word is the shift register including the current bit.
  - bit_cnt wraps to 0.
  - If rx_full=0, or rx_ack=1 in the same cycle: rx_data <= word, rx_full <= 1, rx_strobe <= 1.
  - Otherwise the word is discarded, rx_data is unchanged, and overrun <= 1.
- rx_ack with no completion in the same cycle: rx_full <= 0, overrun <= 0.
- rx_ack while rx_full=0 has no effect.
- Chip select:
  - While sync_ss_n=1: bit_cnt <= 0 and shift_reg <= 0; SCK edges are ignored.
  - sync_ss_n rising mid-word silently aborts the partial word; rx_data, rx_full and overrun are unaffected.
- rx_busy = (bit_cnt != 0) & ~sync_ss_n.
- Reset (n_rst=0 at a clk edge):
  - rx_data=0, rx_full=0, rx_strobe=0, overrun=0, bit_cnt=0, shift_reg=0.
  - sclk_prev=1, which suppresses a false edge if SCK is high when reset releases.
  - Reset overrides every other event, including a completion in the same cycle.

## Timing
- Latency: a word's last bit is visible on sync_sclk high in cycle T; rx_data, rx_full and rx_strobe are valid after the clk edge ending T, i.e. in cycle T+1.
- End-to-end from the raw pad: 2 cycles of synchronizer plus 1 cycle here.
- rx_strobe is high for exactly one cycle per accepted word and never for a dropped word.
- SCK high and SCK low must each last at least 2 clk periods. MOSI must be stable from 2 clk before the SCK rise until 1 clk after it. Faster SCK is unsupported; behaviour is then undefined but must not deadlock, because the next ss_n high recovers.
- Back-to-back words: no dead cycles required between the last bit of one word and the first of the next.
- All outputs are registered; no combinational path from inputs to outputs except rx_busy.

## Test plan
- Reset: hold n_rst=0 for 2 cycles with sync_sclk toggling and sync_ss_n=0 -> all outputs 0. After release with sync_sclk=1, no sample occurs until a genuine 0->1 edge.
- Normal byte: ss_n=0, shift 0xA5 MSB-first at 4 clk per SCK phase -> rx_data=0xA5 and rx_strobe for 1 cycle, 1 cycle after the 8th sync_sclk rise. rx_full stays high until rx_ack, then 0.
- LSB-first: MSB_FIRST=0, send bits 1,0,0,0,0,0,0,0 -> rx_data=0x01.
- Overrun: send 0x3C without ack, then 0xC3 -> rx_data stays 0x3C, overrun=1, no second strobe. rx_ack -> rx_full=0 and overrun=0.
- Simultaneous: assert rx_ack in the same cycle that the 0x81 word completes while 0x7E is held -> rx_data=0x81, rx_full=1, overrun=0.
- Abort: 5 bits sent, then ss_n=1 for 3 cycles, then a full 0x5A -> rx_data=0x5A. rx_busy is 1 during the partial word and 0 after ss_n rises.

Source files
------------

// File: rtl/spi_byte_rx.sv
// SPI-style serial word receiver working on pre-synchronized SCK/MOSI/SS_N lines.
// Assembles NUM_BITS-wide words and holds each one in a full/ack handshake register with overrun flagging.
module spi_byte_rx #(
    parameter int NUM_BITS  = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                sync_sclk,
    input  logic                sync_mosi,
    input  logic                sync_ss_n,
    input  logic                rx_ack,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                rx_full,
    output logic                rx_strobe,
    output logic                rx_busy,
    output logic                overrun
);

    localparam int             CW   = $clog2(NUM_BITS);
    localparam logic [CW-1:0]  LAST = CW'(NUM_BITS - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic                r_sclk_prev;
    logic [NUM_BITS-1:0] r_shift;
    logic [CW-1:0]       r_bit_cnt;
    logic [NUM_BITS-1:0] r_rx_data;
    logic                r_rx_full;
    logic                r_rx_strobe;
    logic                r_overrun;

    logic                w_sample;
    logic                w_complete;
    logic [NUM_BITS-1:0] w_shift_next;
    logic [NUM_BITS-1:0] w_shift_d;
    logic [CW-1:0]       w_cnt_d;
    logic [NUM_BITS-1:0] w_data_d;
    logic                w_full_d;
    logic                w_strobe_d;
    logic                w_ovr_d;

    assign w_sample   = sync_sclk & ~r_sclk_prev & ~sync_ss_n;
    assign w_complete = w_sample & (r_bit_cnt == LAST);

    // Shift register contents including the bit sampled this cycle
    always_comb begin
        w_shift_next = r_shift;
        if (MSB_FIRST) begin
            w_shift_next = {r_shift[NUM_BITS-2:0], sync_mosi};
        end else begin
            w_shift_next = {sync_mosi, r_shift[NUM_BITS-1:1]};
        end
    end

    // Next state of the bit assembly path; chip select high clears everything
    always_comb begin
        w_shift_d = r_shift;
        w_cnt_d   = r_bit_cnt;
        if (sync_ss_n) begin
            w_shift_d = '0;
            w_cnt_d   = '0;
        end else if (w_sample) begin
            w_shift_d = w_shift_next;
            w_cnt_d   = w_complete ? '0 : (r_bit_cnt + ONE);
        end else begin
            w_shift_d = r_shift;
            w_cnt_d   = r_bit_cnt;
        end
    end

    // Holding register handshake: an ack in the completion cycle frees the slot for the new word
    always_comb begin
        w_data_d   = r_rx_data;
        w_full_d   = r_rx_full;
        w_strobe_d = 1'b0;
        w_ovr_d    = r_overrun;
        if (w_complete) begin
            if (!r_rx_full || rx_ack) begin
                w_data_d   = w_shift_next;
                w_full_d   = 1'b1;
                w_strobe_d = 1'b1;
                w_ovr_d    = (rx_ack && r_rx_full) ? 1'b0 : r_overrun;
            end else begin
                w_ovr_d    = 1'b1;
            end
        end else if (rx_ack && r_rx_full) begin
            w_full_d = 1'b0;
            w_ovr_d  = 1'b0;
        end else begin
            w_full_d = r_rx_full;
            w_ovr_d  = r_overrun;
        end
    end

    // State registers; sclk_prev resets high so a high SCK at release is not taken as an edge
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sclk_prev <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_rx_data   <= '0;
            r_rx_full   <= 1'b0;
            r_rx_strobe <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sclk_prev <= sync_sclk;
            r_shift     <= w_shift_d;
            r_bit_cnt   <= w_cnt_d;
            r_rx_data   <= w_data_d;
            r_rx_full   <= w_full_d;
            r_rx_strobe <= w_strobe_d;
            r_overrun   <= w_ovr_d;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_full   = r_rx_full;
    assign rx_strobe = r_rx_strobe;
    assign overrun   = r_overrun;
    assign rx_busy   = (r_bit_cnt != '0) & ~sync_ss_n;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench: an MSB-first and an LSB-first receiver share one serial stream,
// checked against a word-level model of the holding register and overrun rules.
module tb_spi_byte_rx;

    logic       clk = 1'b0;
    logic       n_rst, sclk, mosi, ss_n, ack;
    logic [7:0] m_data, l_data;
    logic       m_full, m_strobe, m_busy, m_ov;
    logic       l_full, l_strobe, l_busy, l_ov;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] exp_ldata = 8'h00;
    bit         exp_full = 1'b0;
    bit         exp_ov = 1'b0;
    int         exp_strobes = 0;
    int         m_strobes = 0;
    int         l_strobes = 0;

    spi_byte_rx #(.NUM_BITS(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .sync_sclk(sclk), .sync_mosi(mosi), .sync_ss_n(ss_n),
        .rx_ack(ack), .rx_data(m_data), .rx_full(m_full), .rx_strobe(m_strobe),
        .rx_busy(m_busy), .overrun(m_ov));

    spi_byte_rx #(.NUM_BITS(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .sync_sclk(sclk), .sync_mosi(mosi), .sync_ss_n(ss_n),
        .rx_ack(ack), .rx_data(l_data), .rx_full(l_full), .rx_strobe(l_strobe),
        .rx_busy(l_busy), .overrun(l_ov));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_strobe) m_strobes++;
        if (l_strobe) l_strobes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = w[7-k];
        return r;
    endfunction

    task automatic check_state(input string nm);
        total++;
        if (m_data !== exp_data || l_data !== exp_ldata) begin
            bad++;
            $display("FAIL %s data: got msb=%h lsb=%h want msb=%h lsb=%h", nm, m_data, l_data, exp_data, exp_ldata);
        end
        total++;
        if (m_full !== exp_full || l_full !== exp_full || m_ov !== exp_ov || l_ov !== exp_ov) begin
            bad++;
            $display("FAIL %s flags: got full=%b/%b ovr=%b/%b want full=%b ovr=%b", nm, m_full, l_full, m_ov, l_ov, exp_full, exp_ov);
        end
    endtask

    // Sends one word first-bit = w[7]; ack_end raises rx_ack in the last bit's sample cycle
    task automatic send_word(input logic [7:0] w, input bit ack_end, input int ph, input string nm);
        bit acc;
        for (int i = 7; i >= 0; i--) begin
            sclk = 1'b0;
            mosi = w[i];
            repeat (ph) tick();
            sclk = 1'b1;
            if (i == 0 && ack_end) ack = 1'b1;
            tick();
            ack = 1'b0;
            if (i == 0) begin
                acc = !exp_full || ack_end;
                if (acc) begin
                    if (ack_end && exp_full) exp_ov = 1'b0;
                    exp_data  = w;
                    exp_ldata = rev8(w);
                    exp_full  = 1'b1;
                    exp_strobes++;
                end else begin
                    exp_ov = 1'b1;
                end
                total++;
                if (m_strobe !== acc || l_strobe !== acc) begin
                    bad++;
                    $display("FAIL %s strobe: got %b/%b want %b", nm, m_strobe, l_strobe, acc);
                end
                total++;
                if (m_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s busy_end: got %b want 0", nm, m_busy);
                end
                check_state(nm);
            end
            repeat (ph - 1) tick();
            if (i == 0) begin
                total++;
                if (m_strobe !== 1'b0 || l_strobe !== 1'b0) begin
                    bad++;
                    $display("FAIL %s strobe_len: got %b/%b want 0", nm, m_strobe, l_strobe);
                end
            end
        end
        sclk = 1'b0;
    endtask

    task automatic do_ack(input string nm);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        if (exp_full) begin
            exp_full = 1'b0;
            exp_ov   = 1'b0;
        end
        check_state(nm);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; ss_n = 1'b0; sclk = 1'b0; mosi = 1'b1; ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sclk = ~sclk;
            tick();
        end
        total++;
        if (m_data !== 8'h00 || m_full !== 1'b0 || m_strobe !== 1'b0 || m_ov !== 1'b0 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h full=%b stb=%b ovr=%b busy=%b want all 0", m_data, m_full, m_strobe, m_ov, m_busy);
        end
        sclk  = 1'b1;
        n_rst = 1'b1;
        repeat (3) tick();
        total++;
        if (m_busy !== 1'b0 || l_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_false_edge: got busy=%b/%b want 0", m_busy, l_busy);
        end
        sclk = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        send_word(8'hA5, 1'b0, 4, "normal");
        repeat (5) tick();
        total++;
        if (m_data !== 8'hA5 || m_full !== 1'b1) begin
            bad++;
            $display("FAIL normal_hold: got data=%h full=%b want a5 1", m_data, m_full);
        end
        do_ack("normal_ack");
    endtask

    task automatic test_lsb();
        send_word(8'h80, 1'b0, 3, "lsb");
        total++;
        if (l_data !== 8'h01) begin
            bad++;
            $display("FAIL lsb_first: got %h want 01", l_data);
        end
        do_ack("lsb_ack");
    endtask

    task automatic test_overrun();
        send_word(8'h3C, 1'b0, 2, "ovr_first");
        send_word(8'hC3, 1'b0, 2, "ovr_second");
        total++;
        if (m_data !== 8'h3C || m_ov !== 1'b1) begin
            bad++;
            $display("FAIL overrun_hold: got data=%h ovr=%b want 3c 1", m_data, m_ov);
        end
        do_ack("ovr_ack");
    endtask

    task automatic test_simultaneous();
        send_word(8'h7E, 1'b0, 2, "sim_first");
        send_word(8'h81, 1'b1, 2, "sim_second");
        total++;
        if (m_data !== 8'h81 || m_full !== 1'b1 || m_ov !== 1'b0) begin
            bad++;
            $display("FAIL simultaneous: got data=%h full=%b ovr=%b want 81 1 0", m_data, m_full, m_ov);
        end
        do_ack("sim_ack");
    endtask

    task automatic test_abort();
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b0;
            mosi = 1'($urandom_range(0, 1));
            repeat (2) tick();
            sclk = 1'b1;
            repeat (2) tick();
        end
        total++;
        if (m_busy !== 1'b1 || l_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_partial: got %b/%b want 1", m_busy, l_busy);
        end
        sclk = 1'b0;
        ss_n = 1'b1;
        repeat (3) tick();
        total++;
        if (m_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy_idle: got %b want 0", m_busy);
        end
        check_state("abort_idle");
        ss_n = 1'b0;
        tick();
        send_word(8'h5A, 1'b0, 2, "abort_word");
        total++;
        if (m_data !== 8'h5A) begin
            bad++;
            $display("FAIL abort_recover: got %h want 5a", m_data);
        end
        do_ack("abort_ack");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            send_word(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(2, 4), "random");
            if ($urandom_range(0, 2) == 0) do_ack("random_ack");
        end
        do_ack("final_ack");
        repeat (2) tick();
        total++;
        if (m_strobes !== exp_strobes || l_strobes !== exp_strobes) begin
            bad++;
            $display("FAIL strobe_count: got %0d/%0d want %0d", m_strobes, l_strobes, exp_strobes);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_lsb();
        test_overrun();
        test_simultaneous();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
